clock_divider_bank: RTL

CLOCK_DIVIDER_BANK -- requirements
Module: clock_divider_bank

---
 rtl/clock_divider_bank_pkg.sv | 30 +++
 rtl/clock_divider_bank_channel.sv | 96 +++++++++
 rtl/clock_divider_bank.sv | 70 +++++++
 3 files changed

// File: rtl/clock_divider_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_pkg
//  Description : Shared defaults, channel-state record and index-width helper
//                for the clock_divider_bank divider slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    // Storage width of the channel-state record. CNT_W must not exceed this.
    // Upper bits beyond CNT_W are always written as zero.
    localparam int c_CLKDIV_CNT_MAX     = 32;
    localparam int c_CLKDIV_CNT_W       = 18;
    localparam int c_CLKDIV_DEFAULT_DIV = 250000;

    // Per-channel state: counter, active divisor, shadow divisor, pending flag
    typedef struct packed {
        logic [c_CLKDIV_CNT_MAX-1:0] cnt;
        logic [c_CLKDIV_CNT_MAX-1:0] div;
        logic [c_CLKDIV_CNT_MAX-1:0] shd;
        logic                        pend;
    } clkdiv_state_t;

    // Width of a channel index; at least one bit even for a single channel
    function automatic int clkdiv_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_divider_bank_channel.sv
`default_nettype none
// ============================================================================
//  Module      : clkdiv_channel
//  Description : One divider channel. Counts 0..div, then emits a one-cycle
//                tick and toggles usr_clk. Divisor changes on a running channel
//                go through a shadow register and take effect only at a
//                terminal count, so the divided clock never glitches.
//                Optional macro CLKDIV_SYNC_EN adds i_sync (phase alignment).
//  Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = c_CLKDIV_CNT_W,
    parameter int DEFAULT_DIV = c_CLKDIV_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_div,
`ifdef CLKDIV_SYNC_EN
    input  logic             i_sync,
`endif
    output logic             o_pend,
    output logic             o_usr_clk,
    output logic             o_tick
);

    localparam logic [c_CLKDIV_CNT_MAX-1:0] c_DEFAULT_DIV = c_CLKDIV_CNT_MAX'(DEFAULT_DIV);

    clkdiv_state_t               r_st;
    logic                        r_usr_clk;
    logic                        r_tick;
    logic                        w_tc;
    logic                        w_sync;
    logic [c_CLKDIV_CNT_MAX-1:0] w_cnt_inc;
    logic [c_CLKDIV_CNT_MAX-1:0] w_load_ext;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = i_sync;
`else
    assign w_sync = 1'b0;
`endif

    // cnt above div can only be transient; treat it as terminal count too
    assign w_tc       = (r_st.cnt >= r_st.div);
    assign w_cnt_inc  = c_CLKDIV_CNT_MAX'(r_st.cnt[CNT_W-1:0] + CNT_W'(1));
    assign w_load_ext = c_CLKDIV_CNT_MAX'(i_load_div);

    // Counter, divisor update, divided clock and tick generation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st      <= '{cnt: '0, div: c_DEFAULT_DIV, shd: '0, pend: 1'b0};
            r_usr_clk <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_sync) begin
                // Phase alignment wins over a coinciding terminal count
                r_st.cnt  <= '0;
                r_usr_clk <= 1'b0;
            end else if (i_enable) begin
                if (w_tc) begin
                    r_st.cnt  <= '0;
                    r_usr_clk <= ~r_usr_clk;
                    r_tick    <= 1'b1;
                    if (r_st.pend) begin
                        r_st.div  <= r_st.shd;
                        r_st.pend <= 1'b0;
                    end
                end else begin
                    r_st.cnt <= w_cnt_inc;
                end
            end
            // An accepted load implies pend was clear, so it never collides
            // with the pending-apply path above; a same-cycle terminal count
            // therefore used the old divisor and this load becomes pending.
            if (i_load) begin
                if (i_enable) begin
                    r_st.shd  <= w_load_ext;
                    r_st.pend <= 1'b1;
                end else begin
                    r_st.div <= w_load_ext;
                    r_st.cnt <= '0;
                end
            end
        end
    end

    assign o_pend    = r_st.pend;
    assign o_usr_clk = r_usr_clk;
    assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module      : clock_divider_bank
//  Description : Bank of NUM_CH independent programmable clock dividers.
//                The top level decodes divisor loads and muxes load_ready;
//                all counting lives in clkdiv_channel.
//                Optional macro CLKDIV_SYNC_EN adds input sync_req, which
//                zeroes every channel's counter and usr_clk on the next cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_bank
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = c_CLKDIV_CNT_W,
    parameter int DEFAULT_DIV = c_CLKDIV_DEFAULT_DIV
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CH-1:0]                 ch_enable,
    input  logic                              load_valid,
    input  logic [clkdiv_idx_w(NUM_CH)-1:0]   load_ch,
    input  logic [CNT_W-1:0]                  load_div,
`ifdef CLKDIV_SYNC_EN
    input  logic                              sync_req,
`endif
    output logic                              load_ready,
    output logic [NUM_CH-1:0]                 usr_clk,
    output logic [NUM_CH-1:0]                 tick
);

    localparam int c_IDX_W  = clkdiv_idx_w(NUM_CH);
    localparam int c_PEND_W = 1 << c_IDX_W;

    logic [NUM_CH-1:0]   w_pend;
    logic [c_PEND_W-1:0] w_pend_ext;
    logic [NUM_CH-1:0]   w_load_hit;
    logic                w_load_fire;

    // Indices with no channel behind them read as not pending; such loads
    // are accepted and dropped.
    assign w_pend_ext  = c_PEND_W'(w_pend);
    assign load_ready  = ~w_pend_ext[load_ch];
    assign w_load_fire = load_valid & load_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_load_hit[gi] = w_load_fire && (load_ch == c_IDX_W'(gi));

            clkdiv_channel #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_channel (
                .clk        (clk),
                .rst        (reset),
                .i_enable   (ch_enable[gi]),
                .i_load     (w_load_hit[gi]),
                .i_load_div (load_div),
`ifdef CLKDIV_SYNC_EN
                .i_sync     (sync_req),
`endif
                .o_pend     (w_pend[gi]),
                .o_usr_clk  (usr_clk[gi]),
                .o_tick     (tick[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire
